// File: rtl/clasificador_pulsacion_pkg.sv
// Shared definitions for the button press classifier: FSM state encoding
// and default timing parameters used by the top level and by benches.
package clasificador_pulsacion_pkg;

  typedef enum logic [1:0] {
    ESPERA_SUELTA = 2'd0,
    REPOSO        = 2'd1,
    PRESIONADO    = 2'd2,
    LARGO         = 2'd3
  } estado_t;

  // 1 s long-press threshold and 200 ms repeat period at 50 MHz
  localparam int unsigned CICLOS_LARGO_DEF      = 50000000;
  localparam int unsigned CICLOS_REPETICION_DEF = 10000000;
  localparam int unsigned ANCHO_CONTADOR_DEF    = 26;
  localparam int unsigned ANCHO_CUENTA_DEF      = 8;

endpackage

// File: rtl/clasificador_pulsacion_contador_ciclos.sv
// Cycle counter shared by the press and long-hold phases. Counts while
// enabled, wraps to zero on the terminal value and flags the wrap with a
// registered one-cycle fin pulse. Clear has priority over enable.
module contador_ciclos #(
  parameter int unsigned ANCHO = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_limpiar,
  input  logic             i_habilitar,
  input  logic [ANCHO-1:0] i_terminal,
  output logic             o_en_terminal,
  output logic             o_fin
);

  logic [ANCHO-1:0] r_cuenta;
  logic             r_fin;

  assign o_en_terminal = (r_cuenta == i_terminal);
  assign o_fin         = r_fin;

  // Count, wrap on equality with the terminal value, pulse fin after a wrap
  always_ff @(posedge clk) begin
    if (reset || i_limpiar) begin
      r_cuenta <= '0;
      r_fin    <= 1'b0;
    end else if (i_habilitar) begin
      if (o_en_terminal) begin
        r_cuenta <= '0;
        r_fin    <= 1'b1;
      end else begin
        r_cuenta <= r_cuenta + ANCHO'(1);
        r_fin    <= 1'b0;
      end
    end else begin
      r_fin <= 1'b0;
    end
  end

endmodule

// File: rtl/clasificador_pulsacion.sv
// Classifies debounced button presses as short or long, emits auto-repeat
// ticks during a held long press and counts short presses.
module clasificador_pulsacion
  import clasificador_pulsacion_pkg::*;
#(
  parameter int unsigned CICLOS_LARGO      = CICLOS_LARGO_DEF,
  parameter int unsigned CICLOS_REPETICION = CICLOS_REPETICION_DEF,
  parameter int unsigned ANCHO_CONTADOR    = ANCHO_CONTADOR_DEF,
  parameter int unsigned ANCHO_CUENTA      = ANCHO_CUENTA_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    boton_filtrado,
  output logic                    presionado,
  output logic                    pulso_corto,
  output logic                    pulso_largo,
  output logic                    pulso_repeticion,
  output logic [ANCHO_CUENTA-1:0] cuenta_cortos
);

  localparam logic [ANCHO_CONTADOR-1:0] LIMITE_LARGO = ANCHO_CONTADOR'(CICLOS_LARGO - 1);
  localparam logic [ANCHO_CONTADOR-1:0] LIMITE_REP   = ANCHO_CONTADOR'(CICLOS_REPETICION - 1);

  estado_t                   r_estado;
  estado_t                   w_estado_sig;
  logic                      w_pulso_corto_sig;
  logic                      w_limpiar;
  logic                      w_habilitar;
  logic [ANCHO_CONTADOR-1:0] w_terminal;
  logic                      w_en_terminal;
  logic                      w_fin;
  logic                      r_pulso_corto;
  logic                      r_presionado;
  logic                      r_desde_presionado;
  logic [ANCHO_CUENTA-1:0]   r_cuenta_cortos;

  // One counter serves both phases; the terminal value follows the state
  contador_ciclos #(
    .ANCHO(ANCHO_CONTADOR)
  ) u_contador (
    .clk          (clk),
    .reset        (reset),
    .i_limpiar    (w_limpiar),
    .i_habilitar  (w_habilitar),
    .i_terminal   (w_terminal),
    .o_en_terminal(w_en_terminal),
    .o_fin        (w_fin)
  );

  // State register; reset lands in ESPERA_SUELTA so a held button is ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado <= ESPERA_SUELTA;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  // Next-state logic and counter control
  always_comb begin
    w_estado_sig      = r_estado;
    w_pulso_corto_sig = 1'b0;
    w_limpiar         = !boton_filtrado || (r_estado == ESPERA_SUELTA);
    w_habilitar       = boton_filtrado && (r_estado != ESPERA_SUELTA);
    w_terminal        = (r_estado == LARGO) ? LIMITE_REP : LIMITE_LARGO;
    case (r_estado)
      ESPERA_SUELTA: begin
        if (!boton_filtrado) w_estado_sig = REPOSO;
      end
      REPOSO: begin
        if (boton_filtrado) w_estado_sig = PRESIONADO;
      end
      PRESIONADO: begin
        if (!boton_filtrado) begin
          w_estado_sig      = REPOSO;
          w_pulso_corto_sig = 1'b1;
        end else if (w_en_terminal) begin
          w_estado_sig = LARGO;
        end
      end
      LARGO: begin
        if (!boton_filtrado) w_estado_sig = REPOSO;
      end
      default: w_estado_sig = ESPERA_SUELTA;
    endcase
  end

  // Output registers; r_desde_presionado tells a long-threshold wrap from a repeat wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pulso_corto      <= 1'b0;
      r_presionado       <= 1'b0;
      r_desde_presionado <= 1'b0;
      r_cuenta_cortos    <= '0;
    end else begin
      r_pulso_corto      <= w_pulso_corto_sig;
      r_presionado       <= (w_estado_sig == PRESIONADO) || (w_estado_sig == LARGO);
      r_desde_presionado <= (r_estado == PRESIONADO);
      if (w_pulso_corto_sig) begin
        r_cuenta_cortos <= r_cuenta_cortos + ANCHO_CUENTA'(1);
      end
    end
  end

  assign presionado       = r_presionado;
  assign pulso_corto      = r_pulso_corto;
  assign pulso_largo      = w_fin && r_desde_presionado;
  assign pulso_repeticion = w_fin && !r_desde_presionado;
  assign cuenta_cortos    = r_cuenta_cortos;

endmodule
